// File: rtl/sisc_rf_pkg.sv
// Shared constants and types for the SISC register-file read stage.
//   DATA_W / ADDR_W / NUM_REGS : register width, index width, register count
//   ZERO_REG                   : hard-wired zero register index
//   rf_state_t                 : read-stage FSM state encoding
//   reg_addr_t / reg_word_t    : register index and register word types
package sisc_rf_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    localparam reg_addr_t ZERO_REG = '0;

    typedef enum logic {
        IDLE   = 1'b0,
        STROBE = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_array.sv
// 16x16 general register file.
//   clk, rst           : clock, synchronous active-high reset (clears every entry)
//   wb_en/wb_addr/wb_data : synchronous write port; writes to R0 are dropped
//   rd_addr_a/rd_data_a   : combinational read port A (R0 reads as 0)
//   rd_addr_b/rd_data_b   : combinational read port B (R0 reads as 0)
// Implemented in flops rather than block RAM: the file needs a full clear on
// reset and two asynchronous read ports.
module rf_array
    import sisc_rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    input  reg_word_t wb_data,
    input  reg_addr_t rd_addr_a,
    output reg_word_t rd_data_a,
    input  reg_addr_t rd_addr_b,
    output reg_word_t rd_data_b
);

    reg_word_t             regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;

    // One-hot write decode; entry 0 is never selected so R0 stays at 0.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_zero
                assign wr_sel[gi] = 1'b0;
            end else begin : g_word
                assign wr_sel[gi] = wb_en && (wb_addr == reg_addr_t'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wb_data;
                end
            end
        end
    end

    // R0 is forced at the read side as well, so it is zero regardless of storage.
    assign rd_data_a = (rd_addr_a == ZERO_REG) ? '0 : regs_reg[rd_addr_a];
    assign rd_data_b = (rd_addr_b == ZERO_REG) ? '0 : regs_reg[rd_addr_b];

endmodule

// File: rtl/rf_read_stage.sv
// Register-file read stage feeding the 16-bit operand mux.
//   clk, rst              : clock, synchronous active-high reset
//   rd_en / rd_ready      : read request handshake (accepted when both are 1)
//   rs_addr / rt_addr     : operand register indices, sampled on accept
//   wb_en/wb_addr/wb_data : write-back port, with write-through to a same-cycle read
//   rs_data / rt_data     : registered operand values
//   rs_new                : one-cycle strobe marking freshly captured operands
// After each accept the stage spends one cycle in STROBE, so rs_new always
// returns low between reads and the mux sees a clean rising edge every time.
module rf_read_stage
    import sisc_rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rd_en,
    output logic      rd_ready,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    input  reg_word_t wb_data,
    output reg_word_t rs_data,
    output reg_word_t rt_data,
    output logic      rs_new
);

    rf_state_t state_reg, state_next;
    reg_word_t rs_data_reg, rs_data_next;
    reg_word_t rt_data_reg, rt_data_next;

    // Operand 0 is Rs, operand 1 is Rt.
    reg_addr_t op_addr  [2];
    reg_word_t op_array [2];
    reg_word_t op_value [2];

    assign op_addr[0] = rs_addr;
    assign op_addr[1] = rt_addr;

    rf_array u_rf_array (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_a (op_addr[0]),
        .rd_data_a (op_array[0]),
        .rd_addr_b (op_addr[1]),
        .rd_data_b (op_array[1])
    );

    // Write-through: a write landing this cycle is visible to the read being
    // accepted on the same edge. R0 never bypasses, it stays zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign op_value[gi] = (wb_en && (wb_addr == op_addr[gi]) && (op_addr[gi] != ZERO_REG))
                                  ? wb_data : op_array[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rs_data_reg <= rs_data_next;
            rt_data_reg <= rt_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rs_data_next = rs_data_reg;
        rt_data_next = rt_data_reg;
        case (state_reg)
            IDLE: begin
                if (rd_en) begin
                    state_next   = STROBE;
                    rs_data_next = op_value[0];
                    rt_data_next = op_value[1];
                end
            end
            STROBE: begin
                // Requests seen here are neither captured nor queued.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decode straight from the state flop.
    assign rd_ready = (state_reg == IDLE);
    assign rs_new   = (state_reg == STROBE);
    assign rs_data  = rs_data_reg;
    assign rt_data  = rt_data_reg;

endmodule

// File: tb/tb_rf_read_stage.sv
module tb_rf_read_stage;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        rd_ready;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        rs_new;

    rf_read_stage dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_ready (rd_ready),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .rs_new   (rs_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
        logic [3:0]  rs_a;
        logic [3:0]  rt_a;
    } exp_t;

    int total = 0;
    int bad   = 0;

    // Reference model: plain register contents plus "was a read accepted
    // on the previous edge" (the stage is busy for one cycle after it).
    logic [15:0] m_regs [16];
    bit          m_busy;
    exp_t        sb_q [$];
    int          accept_cnt = 0;
    int          rise_cnt   = 0;
    int          cyc        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge and advance the model to what the
    // following rising edge must do.
    task automatic step(input bit r, input bit re, input logic [3:0] rsa, input logic [3:0] rta,
                        input bit we, input logic [3:0] wa, input logic [15:0] wd);
        exp_t e;
        bit   acc;
        @(negedge clk);
        rst = r; rd_en = re; rs_addr = rsa; rt_addr = rta;
        wb_en = we; wb_addr = wa; wb_data = wd;
        if (r) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
            m_busy = 1'b0;
        end else begin
            acc = re && !m_busy;
            if (acc) begin
                e.rs_a = rsa;
                e.rt_a = rta;
                e.rs = (rsa == 0) ? 16'h0 : ((we && wa == rsa) ? wd : m_regs[rsa]);
                e.rt = (rta == 0) ? 16'h0 : ((we && wa == rta) ? wd : m_regs[rta]);
                sb_q.push_back(e);
                accept_cnt++;
            end
            if (we && wa != 0) m_regs[wa] = wd;
            m_busy = acc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 4'd0, 0, 4'd0, 16'h0);
    endtask

    // Monitor: samples 1 time unit after each rising edge and compares
    // against the scoreboard independently of the driver.
    initial begin : monitor
        bit          rst_s;
        bit          prev_new;
        logic [15:0] last_rs;
        logic [15:0] last_rt;
        exp_t        e;
        prev_new = 1'b0;
        last_rs  = 16'h0;
        last_rt  = 16'h0;
        forever begin
            @(posedge clk);
            rst_s = rst;
            #1;
            cyc++;
            if (rst_s) begin
                check("reset_rs_new", {31'b0, rs_new}, 32'd0);
                check("reset_rd_ready", {31'b0, rd_ready}, 32'd1);
                check("reset_rs_data", {16'b0, rs_data}, 32'd0);
                check("reset_rt_data", {16'b0, rt_data}, 32'd0);
                last_rs = 16'h0;
                last_rt = 16'h0;
            end else begin
                check("ready_vs_strobe", {31'b0, rd_ready}, {31'b0, ~rs_new});
                if (rs_new) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_strobe", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("rs_data[R%0d]", e.rs_a), {16'b0, rs_data}, {16'b0, e.rs});
                        check($sformatf("rt_data[R%0d]", e.rt_a), {16'b0, rt_data}, {16'b0, e.rt});
                        $display("read rs=R%0d rt=R%0d -> rs_data=%h rt_data=%h", e.rs_a, e.rt_a, rs_data, rt_data);
                        last_rs = e.rs;
                        last_rt = e.rt;
                    end
                end else begin
                    check("rs_data_hold", {16'b0, rs_data}, {16'b0, last_rs});
                    check("rt_data_hold", {16'b0, rt_data}, {16'b0, last_rt});
                end
            end
            if (rs_new && !prev_new) rise_cnt++;
            prev_new = rs_new;
        end
    end

    initial begin : driver
        logic [3:0] ra, ta, wa;
        rst = 1'b1; rd_en = 1'b0; rs_addr = '0; rt_addr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_busy = 1'b0;

        // 1: reset, then idle
        step(1, 0, 4'd0, 4'd0, 0, 4'd0, 16'h0);
        idle(3);

        // 2: write R3, R5 then read them
        step(0, 0, 4'd0, 4'd0, 1, 4'd3, 16'hBEEF);
        step(0, 0, 4'd0, 4'd0, 1, 4'd5, 16'h1234);
        idle(1);
        step(0, 1, 4'd3, 4'd5, 0, 4'd0, 16'h0);
        idle(2);

        // 3: same-cycle write and read of R7 on both operands, then read back
        step(0, 1, 4'd7, 4'd7, 1, 4'd7, 16'hA5A5);
        idle(1);
        step(0, 1, 4'd7, 4'd3, 0, 4'd0, 16'h0);
        idle(2);

        // 4: writes to R0 are discarded, including bypass attempts
        step(0, 0, 4'd0, 4'd0, 1, 4'd0, 16'hFFFF);
        step(0, 1, 4'd0, 4'd5, 0, 4'd0, 16'h0);
        idle(1);
        step(0, 1, 4'd0, 4'd0, 1, 4'd0, 16'hFFFF);
        idle(2);

        // 5: preload R1..R6, then hold rd_en for 6 cycles
        for (int i = 1; i <= 6; i++) step(0, 0, 4'd0, 4'd0, 1, 4'(i), 16'(16'h1100 + i));
        for (int i = 1; i <= 6; i++) step(0, 1, 4'(i), 4'(7 - i), 0, 4'd0, 16'h0);
        idle(2);

        // 6: reset during the strobe cycle, then read R2 again
        step(0, 0, 4'd0, 4'd0, 1, 4'd2, 16'h00FF);
        step(0, 1, 4'd2, 4'd2, 0, 4'd0, 16'h0);
        step(1, 0, 4'd0, 4'd0, 0, 4'd0, 16'h0);
        step(0, 1, 4'd2, 4'd2, 0, 4'd0, 16'h0);
        idle(2);

        // Random traffic, including bypass hits and occasional resets
        for (int n = 0; n < 600; n++) begin
            ra = 4'($urandom_range(0, 15));
            ta = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: wa = ra;
                1: wa = ta;
                default: wa = 4'($urandom_range(0, 15));
            endcase
            step(($urandom_range(0, 79) == 0), $urandom_range(0, 1), ra, ta,
                 $urandom_range(0, 1), wa, 16'($urandom));
        end
        idle(3);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        check("rising_edges_vs_accepts", rise_cnt, accept_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_read_stage.md
Name: rf_read_stage

Overview:
- Register-file read stage of the SISC datapath, directly upstream of the 16-bit operand mux.
- Holds the 16x16 general register file and serves one read request at a time.
- Each request produces registered Rs/Rt operand values plus a single-cycle rs_new strobe. The operand mux captures Rs on the rising edge of that strobe.
- The write-back port updates the register file, with write-through bypass to a read in the same cycle.

Parameters:
DATA_W, 16, register and operand width
ADDR_W, 4, register address width
NUM_REGS, 16, number of registers (2**ADDR_W)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
rd_en  input  1  read request; accepted only when rd_ready=1
rd_ready  output  1  stage can accept a read request this cycle
rs_addr  input  ADDR_W  Rs register index, sampled on accept
rt_addr  input  ADDR_W  Rt register index, sampled on accept
wb_en  input  1  write-back enable
wb_addr  input  ADDR_W  write-back register index
wb_data  input  DATA_W  write-back data
rs_data  output  DATA_W  registered Rs value (feeds operand mux rs_in)
rt_data  output  DATA_W  registered Rt value
rs_new  output  1  one-cycle strobe: rs_data holds a freshly captured value

Behaviour:
- Reset (rst=1 at posedge):
  - all registers R0..R15 cleared to 0
  - rs_data=0, rt_data=0, rs_new=0, rd_ready=1
  - state=IDLE
- Reset takes priority over every other input in that cycle, including wb_en and rd_en.
- Reset while rs_new=1 drops rs_new at that edge. No rising edge is generated.
- R0 reads as 0 at all times. Writes with wb_addr=0 are discarded.
- Write port:
  - when wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data at posedge
  - accepted every cycle, independent of read state
- State machine, two states:
  - IDLE: rd_ready=1, rs_new=0.
    - rd_en=1 accepts the request at this edge: rs_data/rt_data load the selected values and the FSM moves to STROBE.
    - rd_en=0: stay in IDLE; rs_data/rt_data hold.
  - STROBE: rd_ready=0, rs_new=1 for exactly this one cycle.
    - Unconditional return to IDLE at the next edge.
    - rd_en is ignored here: no capture, no queueing. Requester must hold rd_en until it sees rd_ready=1.
- Latency: request accepted in cycle N. Data valid and rs_new=1 in cycle N+1. rs_new=0 and rd_ready=1 in cycle N+2.
- Maximum throughput is one read per 2 cycles. This guarantees rs_new returns low between strobes, so every read gives the mux a clean rising edge.
- rs_new and rd_ready are registered (FSM-decoded from state flops), not combinational from inputs.
- Bypass: in the accept cycle, if wb_en=1 and wb_addr==rs_addr!=0, rs_data loads wb_data instead of the array value. The same rule applies independently to rt_addr/rt_data.
- Both operands may bypass the same write.
- rs_data/rt_data are stable except at the accept edge and at reset.
- No X propagation: array contents are always defined after reset.

Decomposition:
- Package sisc_rf_pkg:
  - constants DATA_W=16, ADDR_W=4, NUM_REGS=16, ZERO_REG=0
  - typedef rf_state_t {IDLE, STROBE}
  - typedefs reg_addr_t, reg_word_t
- Sub-module rf_array:
  - storage, synchronous write port, R0 write-discard
  - two combinational read ports, R0 forced to 0
  - reset clears all entries
- rf_read_stage contains the FSM, bypass muxing and output registers.

Test Plan:
1. Reset, then idle 3 cycles -> rs_data=0, rt_data=0, rs_new=0, rd_ready=1 throughout.
2. Write R3=0xBEEF and R5=0x1234. Then in a later cycle rd_en with rs_addr=3, rt_addr=5 -> next cycle rs_data=0xBEEF, rt_data=0x1234, rs_new=1, rd_ready=0. Following cycle rs_new=0, rd_ready=1, data held.
3. Same-cycle write R7=0xA5A5 with rd_en, rs_addr=7, rt_addr=7 -> both outputs 0xA5A5 next cycle; reg[7]=0xA5A5 afterwards.
4. wb_en with wb_addr=0, wb_data=0xFFFF, then read rs_addr=0 -> rs_data=0x0000. Also with a same-cycle bypass attempt on R0 -> rs_data=0x0000.
5. rd_en held high for 6 consecutive cycles with rs_addr varying 1,2,3,4,5,6 (R1..R6 preloaded) -> captures only in accept cycles 1,3,5 (addresses 1,3,5). rs_new pattern is 0,1,0,1,0,1 (one cycle behind accepts). Exactly 3 rising edges on rs_new.
6. Accept a read of R2=0x00FF, then assert rst during the STROBE cycle -> next cycle rs_new=0, rs_data=0, rd_ready=1. Subsequent read of R2 returns 0x0000.
